// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory stage: FSM states, IO-window
// offsets and the lane-slice helper used to address one lane of a packed vector.
package vmem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int GPIO_GEN = 0;
   localparam int GPIO_R   = 1;
   localparam int GPIO_G   = 2;
   localparam int GPIO_B   = 3;
   localparam int SW_RD    = 0;

   // LSB position of lane 'lane' inside a packed LANES*lane_w vector.
   function automatic int lane_lsb(input int lane, input int lane_w);
      return lane * lane_w;
   endfunction

endpackage

// File: rtl/vmem_ram.sv
// Single-port synchronous data RAM, write-first; read data one cycle after issue.
// No backpressure: accepts one access per cycle; contents are never reset.
module vmem_ram #(
   parameter int DEPTH  = 4096,
   parameter int LANE_W = 32,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [LANE_W-1:0] wdata_i,
   output logic [LANE_W-1:0] rdata_o
);

   logic [LANE_W-1:0] mem [DEPTH];
   logic [LANE_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
         rdata_q     <= wdata_i;
      end else begin
         rdata_q     <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/vector_memory_stage.sv
// MEM stage: scalar/vector loads and stores, one lane per cycle, plus a GPIO/switch IO window.
// Result strobe N+2 cycles after accept (1 for passthrough); stall holds upstream while busy.
module vector_memory_stage
   import vmem_pkg::*;
#(
   parameter int             LANES   = 4,
   parameter int             LANE_W  = 32,
   parameter int             ADDR_W  = 16,
   parameter int             DEPTH   = 4096,
   parameter logic [15:0]    IO_BASE = 16'hF000,
   parameter int             SW_W    = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic                    wmem,
   input  logic                    rmem,
   input  logic                    vf,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [LANES*LANE_W-1:0] wdata,
   input  logic [LANES*LANE_W-1:0] pass_data,
   input  logic [SW_W-1:0]         sw,
   output logic                    stall,
   output logic                    res_valid,
   output logic [LANES*LANE_W-1:0] res_data,
   output logic [31:0]             gpio,
   output logic [3:0]              gpio_en
);

   localparam int DW     = LANES * LANE_W;
   localparam int RAM_AW = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(LANES + 1);

   state_t              state_q;
   logic [CNT_W-1:0]    lane_q, n_q, rd_lane_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DW-1:0]       wdata_q, pass_q, asm_q, asm_d;
   logic                store_q, stall_q, res_valid_q;
   logic [DW-1:0]       res_data_q;
   logic [31:0]         gpio_q;
   logic [3:0]          gpio_en_q;
   logic                rd_pend_q, rd_ram_q;
   logic [LANE_W-1:0]   io_rdata_q;
   logic [SW_W-1:0]     sw_meta_q, sw_sync_q;

   logic [ADDR_W-1:0]   lane_addr, io_off;
   logic [LANE_W-1:0]   lane_wdata, ram_rdata, rd_data;
   logic                in_ram, in_io, gpio_hit, sw_hit, ram_we, last_lane;
   logic [3:0]          gpio_strobe;

   always_comb begin
      lane_addr   = addr_q + ADDR_W'(lane_q);
      lane_wdata  = wdata_q[lane_lsb(int'(lane_q), LANE_W) +: LANE_W];
      in_ram      = ({1'b0, lane_addr} < (ADDR_W+1)'(DEPTH));
      in_io       = (lane_addr >= ADDR_W'(IO_BASE));
      io_off      = lane_addr - ADDR_W'(IO_BASE);
      gpio_hit    = in_io && (io_off < ADDR_W'(4));
      sw_hit      = in_io && (io_off == ADDR_W'(SW_RD));
      last_lane   = (lane_q == n_q - CNT_W'(1));
      // Reset must also suppress the in-flight lane so an aborted burst stops cleanly.
      ram_we      = (state_q == BURST) && store_q && in_ram && !rst;
      rd_data     = rd_ram_q ? ram_rdata : io_rdata_q;
      gpio_strobe = 4'b0000;
      case (io_off[1:0])
         2'(GPIO_GEN): gpio_strobe = 4'b0001;
         2'(GPIO_R):   gpio_strobe = 4'b0010;
         2'(GPIO_G):   gpio_strobe = 4'b0100;
         2'(GPIO_B):   gpio_strobe = 4'b1000;
         default:      gpio_strobe = 4'b0000;
      endcase
      asm_d = asm_q;
      if (rd_pend_q && !store_q) begin
         asm_d[lane_lsb(int'(rd_lane_q), LANE_W) +: LANE_W] = rd_data;
      end
   end

   vmem_ram #(
      .DEPTH  (DEPTH),
      .LANE_W (LANE_W),
      .AW     (RAM_AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (lane_addr[RAM_AW-1:0]),
      .wdata_i (lane_wdata),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lane_q      <= '0;
         n_q         <= '0;
         rd_lane_q   <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         pass_q      <= '0;
         asm_q       <= '0;
         store_q     <= 1'b0;
         stall_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         gpio_q      <= '0;
         gpio_en_q   <= '0;
         rd_pend_q   <= 1'b0;
         rd_ram_q    <= 1'b0;
         io_rdata_q  <= '0;
      end else begin
         res_valid_q <= 1'b0;
         gpio_en_q   <= '0;
         rd_pend_q   <= 1'b0;
         asm_q       <= asm_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (wmem || rmem) begin
                     state_q <= BURST;
                     stall_q <= 1'b1;
                     lane_q  <= '0;
                     n_q     <= vf ? CNT_W'(LANES) : CNT_W'(1);
                     addr_q  <= addr;
                     wdata_q <= wdata;
                     pass_q  <= pass_data;
                     store_q <= wmem;
                     asm_q   <= '0;
                  end else begin
                     res_valid_q <= 1'b1;
                     res_data_q  <= pass_data;
                  end
               end
            end
            BURST: begin
               rd_pend_q  <= 1'b1;
               rd_lane_q  <= lane_q;
               rd_ram_q   <= in_ram;
               io_rdata_q <= sw_hit ? LANE_W'(sw_sync_q) : '0;
               if (store_q && gpio_hit) begin
                  gpio_q    <= 32'(lane_wdata);
                  gpio_en_q <= gpio_strobe;
               end
               lane_q <= lane_q + CNT_W'(1);
               if (last_lane) state_q <= DRAIN;
            end
            DRAIN: begin
               state_q     <= IDLE;
               stall_q     <= 1'b0;
               res_valid_q <= 1'b1;
               res_data_q  <= store_q ? pass_q : asm_d;
            end
            default: begin
               state_q <= IDLE;
               stall_q <= 1'b0;
            end
         endcase
      end
   end

   assign stall     = stall_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign gpio      = gpio_q;
   assign gpio_en   = gpio_en_q;

endmodule

// File: tb/tb_vector_memory_stage.sv
// Directed bench for vector_memory_stage: table of request records plus hand-written
// sequences for switch synchronisation and reset during a vector burst.
module tb_vector_memory_stage;

   localparam int          LANES   = 4;
   localparam int          LANE_W  = 32;
   localparam int          ADDR_W  = 16;
   localparam int          DEPTH   = 4096;
   localparam logic [15:0] IO_BASE = 16'hF000;
   localparam int          SW_W    = 24;
   localparam int          DW      = LANES * LANE_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              wmem = 1'b0;
   logic              rmem = 1'b0;
   logic              vf = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DW-1:0]     wdata = '0;
   logic [DW-1:0]     pass_data = '0;
   logic [SW_W-1:0]   sw = '0;
   logic              stall;
   logic              res_valid;
   logic [DW-1:0]     res_data;
   logic [31:0]       gpio;
   logic [3:0]        gpio_en;

   vector_memory_stage #(
      .LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W),
      .DEPTH(DEPTH), .IO_BASE(IO_BASE), .SW_W(SW_W)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .wmem(wmem), .rmem(rmem),
      .vf(vf), .addr(addr), .wdata(wdata), .pass_data(pass_data), .sw(sw),
      .stall(stall), .res_valid(res_valid), .res_data(res_data),
      .gpio(gpio), .gpio_en(gpio_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wmem, rmem, vf;
      logic [15:0]   addr;
      logic [DW-1:0] wdata, pass;
      logic          hold;
      int            exp_cyc;
      int            exp_stall;
      logic [DW-1:0] exp_data;
      logic          chk_gpio;
      logic [31:0]   exp_gpio;
      logic [3:0]    exp_en;
      int            exp_en_cnt;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic w, input logic r, input logic v, input logic [15:0] a,
                               input logic [DW-1:0] wd, input logic [DW-1:0] pd, input logic h,
                               input int cyc, input int stl, input logic [DW-1:0] ed,
                               input logic cg, input logic [31:0] eg, input logic [3:0] ee,
                               input int ec);
      vec_t t;
      t.wmem = w; t.rmem = r; t.vf = v; t.addr = a; t.wdata = wd; t.pass = pd; t.hold = h;
      t.exp_cyc = cyc; t.exp_stall = stl; t.exp_data = ed;
      t.chk_gpio = cg; t.exp_gpio = eg; t.exp_en = ee; t.exp_en_cnt = ec;
      return t;
   endfunction

   // Drive one request, follow it to its result strobe (bounded), then check everything.
   task automatic run(input vec_t v, input string tag);
      int            c, rc, stall_cnt, en_cnt;
      logic [3:0]    en_or;
      logic [DW-1:0] data;
      logic          got;
      wmem = v.wmem; rmem = v.rmem; vf = v.vf; addr = v.addr;
      wdata = v.wdata; pass_data = v.pass; req_valid = 1'b1;
      step();
      c = 1; rc = 0; stall_cnt = 0; en_cnt = 0; en_or = '0; data = '0; got = 1'b0;
      if (!v.hold) req_valid = 1'b0;
      while (!got && c <= 20) begin
         if (stall) stall_cnt++;
         if (gpio_en != 4'b0) begin
            en_or = en_or | gpio_en;
            en_cnt++;
         end
         if (res_valid) begin
            got = 1'b1;
            rc = c;
            data = res_data;
            req_valid = 1'b0;
         end else begin
            step();
            c++;
         end
      end
      req_valid = 1'b0;
      chk({tag, " res_cycle"}, DW'(rc), DW'(v.exp_cyc));
      chk({tag, " res_data"}, data, v.exp_data);
      chk({tag, " stall_cycles"}, DW'(stall_cnt), DW'(v.exp_stall));
      if (v.chk_gpio) begin
         chk({tag, " gpio"}, DW'(gpio), DW'(v.exp_gpio));
         chk({tag, " gpio_en_seen"}, DW'(en_or), DW'(v.exp_en));
         chk({tag, " gpio_en_cycles"}, DW'(en_cnt), DW'(v.exp_en_cnt));
      end
      step();
      chk({tag, " res_valid_oneshot"}, DW'(res_valid), DW'(0));
      chk({tag, " no_second_access"}, DW'(stall), DW'(0));
   endtask

   vec_t tbl[13];

   initial begin
      int rv_cnt;

      tbl[0]  = mk(0,0,0, 16'd0,   '0, DW'(128'hA5), 0, 1, 0, DW'(128'hA5), 0, 0, 0, 0);
      tbl[1]  = mk(1,0,0, 16'd10,  DW'(32'hDEADBEEF), DW'(128'h1111), 0, 3, 2, DW'(128'h1111), 0, 0, 0, 0);
      tbl[2]  = mk(0,1,0, 16'd10,  '0, {DW{1'b1}}, 0, 3, 2, DW'(32'hDEADBEEF), 0, 0, 0, 0);
      tbl[3]  = mk(1,0,1, 16'd100, {32'd4, 32'd3, 32'd2, 32'd1}, DW'(128'h2222), 0, 6, 5, DW'(128'h2222), 0, 0, 0, 0);
      tbl[4]  = mk(0,1,1, 16'd100, '0, DW'(128'h3333), 1, 6, 5, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 0, 0);
      tbl[5]  = mk(1,0,0, IO_BASE + 16'd2, DW'(32'h00FF00), DW'(128'h44), 0, 3, 2, DW'(128'h44), 1, 32'h00FF00, 4'b0100, 1);
      tbl[6]  = mk(0,1,0, 16'h8000, '0, DW'(128'h55), 0, 3, 2, '0, 0, 0, 0, 0);
      tbl[7]  = mk(1,1,1, 16'd0,   {32'hA3, 32'hA2, 32'hA1, 32'hA0}, DW'(128'h66), 0, 6, 5, DW'(128'h66), 0, 0, 0, 0);
      tbl[8]  = mk(0,1,1, 16'hFFFE, '0, DW'(128'h77), 0, 6, 5, {32'hA1, 32'hA0, 32'h0, 32'h0}, 0, 0, 0, 0);
      tbl[9]  = mk(1,0,1, DEPTH - 2, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, DW'(128'h88), 0, 6, 5, DW'(128'h88), 0, 0, 0, 0);
      tbl[10] = mk(0,1,1, DEPTH - 2, '0, DW'(128'h99), 0, 6, 5, {32'h0, 32'h0, 32'hC1, 32'hC0}, 0, 0, 0, 0);
      tbl[11] = mk(1,0,1, IO_BASE, {32'h40, 32'h30, 32'h20, 32'h10}, DW'(128'hAA), 0, 6, 5, DW'(128'hAA), 1, 32'h40, 4'b1111, 4);
      tbl[12] = mk(1,0,1, 16'd200, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, DW'(128'hBB), 0, 6, 5, DW'(128'hBB), 0, 0, 0, 0);

      rst = 1'b1;
      step();
      step();
      chk("reset stall", DW'(stall), DW'(0));
      chk("reset res_valid", DW'(res_valid), DW'(0));
      chk("reset res_data", res_data, '0);
      chk("reset gpio", DW'(gpio), DW'(0));
      chk("reset gpio_en", DW'(gpio_en), DW'(0));
      rst = 1'b0;
      step();

      for (int i = 0; i < 13; i++) begin
         run(tbl[i], $sformatf("vec%0d", i));
      end

      // Switch value must cross the synchroniser before the read is issued.
      sw = 24'h123456;
      step();
      step();
      run(mk(0,1,0, IO_BASE, '0, DW'(128'hCC), 0, 3, 2, DW'(32'h00123456), 0, 0, 0, 0), "sw_read");
      run(mk(0,1,0, IO_BASE + 16'd1, '0, DW'(128'hCC), 0, 3, 2, '0, 0, 0, 0, 0), "io_other_read");

      // Reset while lane 2 of a vector store to 200 is being issued.
      wmem = 1'b1; rmem = 1'b0; vf = 1'b1; addr = 16'd200;
      wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0}; pass_data = DW'(128'hDD); req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      chk("abort stall", DW'(stall), DW'(0));
      chk("abort res_valid", DW'(res_valid), DW'(0));
      chk("abort res_data", res_data, '0);
      chk("abort gpio", DW'(gpio), DW'(0));
      rst = 1'b0;
      rv_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (res_valid || stall) rv_cnt++;
         step();
      end
      chk("abort quiet", DW'(rv_cnt), DW'(0));
      run(mk(0,1,1, 16'd200, '0, DW'(128'hEE), 0, 6, 5, {32'hB3, 32'hB2, 32'hD1, 32'hD0}, 0, 0, 0, 0), "abort_readback");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_memory_stage.md
Name: vector_memory_stage

Overview:
- Parametrised MEM-stage successor for the vector ASIP.
- Serves scalar and vector loads/stores from the EX/MEM pipeline register through a single-port data RAM, one lane per cycle.
- Maps the switch bank and the RGB/generic GPIO outputs into a high IO address window.
- Holds the pipeline via stall during multi-cycle accesses and returns a registered write-back result (loaded data or passthrough).

Parameters:
LANES, 4, lanes per vector access
LANE_W, 32, bits per lane/word
ADDR_W, 16, word-address width
DEPTH, 4096, data RAM words (power of two, <= IO_BASE)
IO_BASE, 16'hF000, first IO-window word address
SW_W, 24, switch input width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present; sampled only in IDLE
wmem  in  1  store
rmem  in  1  load
vf  in  1  1 = vector (LANES words), 0 = scalar (lane 0 only)
addr  in  ADDR_W  base word address (ALU result)
wdata  in  LANES*LANE_W  store data; lane i = bits [i*LANE_W +: LANE_W]
pass_data  in  LANES*LANE_W  result used when not loading
sw  in  SW_W  asynchronous switches
stall  out  1  high while state != IDLE
res_valid  out  1  one-cycle result strobe
res_data  out  LANES*LANE_W  write-back data
gpio  out  32  GPIO data register
gpio_en  out  4  one-cycle strobes: [0] generic, [1] R, [2] G, [3] B

Behaviour:
- Reset values: state IDLE; stall, res_valid, gpio_en, gpio, res_data and sync flops all 0. RAM contents are not reset.
- Reset mid-burst aborts the access. Lanes already written stay written. No res_valid is produced.
- FSM IDLE -> BURST -> DRAIN -> IDLE.
- Accept: cycle 0 is IDLE with req_valid.
  - Neither wmem nor rmem: stay IDLE. res_valid=1 with res_data=pass_data in cycle 1.
  - Otherwise: N = vf ? LANES : 1 and lane counter = 0. Latch addr, wdata, pass_data, op. Go to BURST.
- BURST (cycles 1..N): issue lane k at word address (addr+k) mod 2^ADDR_W, then increment k. After k = N-1, go to DRAIN.
- DRAIN (cycle N+1): capture the last read lane, then go to IDLE.
- res_valid is high in cycle N+2 only:
  - load: res_data = assembled lanes; lanes >= N are 0.
  - store: res_data = latched pass_data.
- A new request may be accepted in the same cycle res_valid is high.
- wmem and rmem both set: treated as a store.
- req_valid while stall is high is ignored. Upstream holds the request.
- Lane address decode, per lane:
  - Below DEPTH: RAM word. Read data arrives one cycle after issue.
  - DEPTH up to IO_BASE-1: writes dropped, reads return 0.
  - IO_BASE+0..3 write: gpio <= lane data. Pulse gpio_en[offset] in the issue cycle + 1.
  - IO_BASE+0 read: {0, sw_sync}.
  - Other IO addresses: read 0, writes ignored.
- sw passes through a 2-flop synchroniser. A change is visible to a read issued 2 cycles later.
- Multiple GPIO writes in one vector burst: last lane wins; each write pulses its own strobe.

Decomposition:
- Package vmem_pkg holds:
  - state enum (IDLE, BURST, DRAIN)
  - IO offsets: GPIO_GEN=0, GPIO_R=1, GPIO_G=2, GPIO_B=3, SW_RD=0
  - lane-slice helper function
- Sub-module vmem_ram: single-port synchronous RAM, DEPTH x LANE_W, write-first, one-cycle read latency.

Test Plan:
- Passthrough: req_valid, wmem=rmem=0, pass_data=128'hA5 -> res_valid cycle 1, res_data=128'hA5, stall never high.
- Scalar: store addr 10, lane0=32'hDEADBEEF; then load addr 10 -> res_valid at cycle 3 after accept, res_data=32'hDEADBEEF zero-extended, stall high cycles 1-2.
- Vector: store addr 100, lanes {4,3,2,1}; load addr 100 -> res_valid cycle 6, same lanes. req_valid held during stall creates no second access.
- GPIO: scalar store IO_BASE+2, data 32'h00FF00 -> gpio=32'h00FF00, gpio_en=4'b0100 for exactly one cycle.
- Switches: sw=24'h123456, then load IO_BASE after 2 cycles -> lane0=32'h00123456. Load at 0x8000 -> 0.
- Reset: assert rst during BURST of a vector store at lane 2 -> next cycle IDLE, stall=0, no res_valid; lanes 0-1 readable with new data, lanes 2-3 with old data.
